// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-select codes and default field widths
// for the forwarding/hazard logic.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RF    = 2'b00;
  localparam sel_t SEL_EXMEM = 2'b01;
  localparam sel_t SEL_MEMWB = 2'b10;
  localparam sel_t SEL_IMM   = 2'b11;

endpackage

// File: rtl/fwd_tag_cmp.sv
// Compares one ID source register against one in-flight stage tag and
// reports whether that stage will produce the value the source needs.
module fwd_tag_cmp
  import pipe_pkg::*;
#(
  parameter int reg_addr_width     = REG_ADDR_W,
  parameter bit zero_reg_hardwired = 1'b1
) (
  input  logic                      tag_valid,
  input  logic [reg_addr_width-1:0] tag_rd,
  input  logic                      tag_reg_write,
  input  logic [reg_addr_width-1:0] src,
  input  logic                      uses,
  output logic                      hit
);

  logic zero_dest;

  // A hardwired r0 is never a real producer, whatever the tag claims.
  assign zero_dest = zero_reg_hardwired && (tag_rd == '0);
  assign hit       = tag_valid & tag_reg_write & uses & (tag_rd == src) & ~zero_dest;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for a 5-stage pipeline.
// Selects are resolved in ID and registered for the EX-stage operand muxes.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int reg_addr_width     = REG_ADDR_W,
  parameter bit zero_reg_hardwired = 1'b1,
  parameter int cnt_width          = CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [reg_addr_width-1:0] id_rs,
  input  logic [reg_addr_width-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_use_imm,
  input  logic [reg_addr_width-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  output logic                      stall_id,
  output logic [1:0]                ex_sel_a,
  output logic [1:0]                ex_sel_b,
  output logic [cnt_width-1:0]      stall_count
);

  typedef struct packed {
    logic                      valid;
    logic [reg_addr_width-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } ex_tag_t;

  // Past EX only forwarding matters; the WB stage needs no tag because the
  // register file writes in the first half-cycle.
  typedef struct packed {
    logic                      valid;
    logic [reg_addr_width-1:0] rd;
    logic                      reg_write;
  } mem_tag_t;

  ex_tag_t  ex_tag;
  ex_tag_t  next_ex;
  mem_tag_t mem_tag;

  logic hit_a_ex, hit_b_ex, hit_a_mem, hit_b_mem;
  logic bubble;
  sel_t sel_a_next, sel_b_next;

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Newest producer wins: EX result beats the older MEM result.
  function automatic sel_t pick_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return SEL_EXMEM;
    if (hit_mem) return SEL_MEMWB;
    return SEL_RF;
  endfunction

  fwd_tag_cmp #(.reg_addr_width(reg_addr_width), .zero_reg_hardwired(zero_reg_hardwired)) u_cmp_a_ex (
    .tag_valid(ex_tag.valid), .tag_rd(ex_tag.rd), .tag_reg_write(ex_tag.reg_write),
    .src(id_rs), .uses(id_uses_rs), .hit(hit_a_ex));

  fwd_tag_cmp #(.reg_addr_width(reg_addr_width), .zero_reg_hardwired(zero_reg_hardwired)) u_cmp_b_ex (
    .tag_valid(ex_tag.valid), .tag_rd(ex_tag.rd), .tag_reg_write(ex_tag.reg_write),
    .src(id_rt), .uses(id_uses_rt), .hit(hit_b_ex));

  fwd_tag_cmp #(.reg_addr_width(reg_addr_width), .zero_reg_hardwired(zero_reg_hardwired)) u_cmp_a_mem (
    .tag_valid(mem_tag.valid), .tag_rd(mem_tag.rd), .tag_reg_write(mem_tag.reg_write),
    .src(id_rs), .uses(id_uses_rs), .hit(hit_a_mem));

  fwd_tag_cmp #(.reg_addr_width(reg_addr_width), .zero_reg_hardwired(zero_reg_hardwired)) u_cmp_b_mem (
    .tag_valid(mem_tag.valid), .tag_rd(mem_tag.rd), .tag_reg_write(mem_tag.reg_write),
    .src(id_rt), .uses(id_uses_rt), .hit(hit_b_mem));

  // ID stage: hazard detection and select resolution
  always_comb begin
    stall_id   = ~rst & id_valid & ~flush & ex_tag.mem_read & (hit_a_ex | hit_b_ex);
    bubble     = flush | stall_id | ~id_valid;
    next_ex    = '0;
    sel_a_next = SEL_RF;
    sel_b_next = SEL_RF;
    if (!bubble) begin
      next_ex.valid     = 1'b1;
      next_ex.rd        = id_rd;
      next_ex.reg_write = id_reg_write;
      next_ex.mem_read  = id_mem_read;
      sel_a_next        = pick_sel(hit_a_ex, hit_a_mem);
      sel_b_next        = id_use_imm ? SEL_IMM : pick_sel(hit_b_ex, hit_b_mem);
    end
  end

  // ID -> EX -> MEM boundary registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag      <= '0;
      mem_tag     <= '0;
      ex_sel_a    <= SEL_RF;
      ex_sel_b    <= SEL_RF;
      stall_count <= '0;
    end else if (!hold) begin
      ex_tag            <= next_ex;
      mem_tag.valid     <= ex_tag.valid;
      mem_tag.rd        <= ex_tag.rd;
      mem_tag.reg_write <= ex_tag.reg_write;
      ex_sel_a          <= sel_a_next;
      ex_sel_b          <= sel_b_next;
      if (stall_id) stall_count <= sat_inc(stall_count);
    end
  end

endmodule
